// File: rtl/mux_scan_if.sv
// Bundles the scan-sequencer command, mux-sample and snapshot signals.
// The master drives scan commands and the mux output; the slave is the sequencer.
interface mux_scan_if #(
    parameter int NCH     = 4,
    parameter int DWELL_W = 4
);
    logic               start;
    logic               stop;
    logic [NCH-1:0]     chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic               mux_in;
    logic [1:0]         sel;
    logic               sel_valid;
    logic [NCH-1:0]     sample;
    logic               sample_valid;
    logic               busy;

    modport master (
        output start, stop, chan_mask, dwell, mux_in,
        input  sel, sel_valid, sample, sample_valid, busy
    );

    modport slave (
        input  start, stop, chan_mask, dwell, mux_in,
        output sel, sel_valid, sample, sample_valid, busy
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Round-robin 4:1 mux scan sequencer: dwells D+1 cycles on each enabled channel,
// captures the mux output at the end of each window, publishes one snapshot per sweep.
module mux_scan_sequencer #(
    parameter int NCH     = 4,
    parameter int DWELL_W = 4
) (
    input  logic      clk,
    input  logic      rst,
    mux_scan_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [1:0]         sel_r, sel_s;
    logic               sel_valid_r, sel_valid_s;
    logic               busy_r, busy_s;
    logic [DWELL_W-1:0] cnt_r, cnt_s;
    logic [NCH-1:0]     mask_r, mask_s;
    logic [DWELL_W-1:0] dwell_r, dwell_s;
    logic [NCH-1:0]     capture_r, capture_s;
    logic [NCH-1:0]     cap_next_s;
    logic [NCH-1:0]     sample_r, sample_s;
    logic               sample_valid_r, sample_valid_s;
    logic               stop_pending_r, stop_pending_s;

    function automatic logic [1:0] lowest_chan(input logic [NCH-1:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (m[k]) r = 2'(k);
        end
        return r;
    endfunction

    function automatic logic has_higher(input logic [NCH-1:0] m, input logic [1:0] cur);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (k > int'(cur) && m[k]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [1:0] next_chan(input logic [NCH-1:0] m, input logic [1:0] cur);
        logic [1:0] r;
        r = cur;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (k > int'(cur) && m[k]) r = 2'(k);
        end
        return r;
    endfunction

    // Next-state, dwell counting, capture and snapshot logic
    always_comb begin
        state_s        = state_r;
        sel_s          = sel_r;
        cnt_s          = cnt_r;
        mask_s         = mask_r;
        dwell_s        = dwell_r;
        capture_s      = capture_r;
        sample_s       = sample_r;
        sample_valid_s = 1'b0;
        stop_pending_s = stop_pending_r;
        cap_next_s         = capture_r;
        cap_next_s[sel_r]  = bus.mux_in;

        case (state_r)
            ST_IDLE: begin
                if (bus.start && (bus.chan_mask != {NCH{1'b0}})) begin
                    mask_s         = bus.chan_mask;
                    dwell_s        = bus.dwell;
                    capture_s      = {NCH{1'b0}};
                    stop_pending_s = 1'b0;
                    sel_s          = lowest_chan(bus.chan_mask);
                    cnt_s          = bus.dwell;
                    state_s        = ST_DWELL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (bus.stop) begin
                    stop_pending_s = 1'b1;
                end else begin
                    stop_pending_s = stop_pending_r;
                end
                if (cnt_r != {DWELL_W{1'b0}}) begin
                    cnt_s = cnt_r - DWELL_W'(1);
                end else if (has_higher(mask_r, sel_r)) begin
                    sel_s     = next_chan(mask_r, sel_r);
                    cnt_s     = dwell_r;
                    capture_s = cap_next_s;
                end else begin
                    // Sweep complete: publish, then either halt or relatch and restart
                    sample_s       = cap_next_s;
                    sample_valid_s = 1'b1;
                    capture_s      = {NCH{1'b0}};
                    if (stop_pending_r || bus.stop) begin
                        state_s        = ST_IDLE;
                        sel_s          = 2'd0;
                        cnt_s          = {DWELL_W{1'b0}};
                        stop_pending_s = 1'b0;
                    end else begin
                        mask_s  = bus.chan_mask;
                        dwell_s = bus.dwell;
                        if (bus.chan_mask != {NCH{1'b0}}) begin
                            sel_s = lowest_chan(bus.chan_mask);
                            cnt_s = bus.dwell;
                        end else begin
                            state_s = ST_IDLE;
                            sel_s   = 2'd0;
                            cnt_s   = {DWELL_W{1'b0}};
                        end
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                sel_s   = 2'd0;
                cnt_s   = {DWELL_W{1'b0}};
            end
        endcase

        sel_valid_s = (state_s == ST_DWELL);
        busy_s      = (state_s != ST_IDLE);
    end

    // State and registered outputs, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            sel_r          <= 2'd0;
            sel_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
            cnt_r          <= {DWELL_W{1'b0}};
            mask_r         <= {NCH{1'b0}};
            dwell_r        <= {DWELL_W{1'b0}};
            capture_r      <= {NCH{1'b0}};
            sample_r       <= {NCH{1'b0}};
            sample_valid_r <= 1'b0;
            stop_pending_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            sel_r          <= sel_s;
            sel_valid_r    <= sel_valid_s;
            busy_r         <= busy_s;
            cnt_r          <= cnt_s;
            mask_r         <= mask_s;
            dwell_r        <= dwell_s;
            capture_r      <= capture_s;
            sample_r       <= sample_s;
            sample_valid_r <= sample_valid_s;
            stop_pending_r <= stop_pending_s;
        end
    end

    assign bus.sel          = sel_r;
    assign bus.sel_valid    = sel_valid_r;
    assign bus.busy         = busy_r;
    assign bus.sample       = sample_r;
    assign bus.sample_valid = sample_valid_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: a cycle-by-cycle vector table for
// a full sweep plus stop, and directed sequences for the multi-cycle corner cases.
module tb_mux_scan_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_scan_if #(.NCH(4), .DWELL_W(4)) bus ();

    mux_scan_sequencer #(.NCH(4), .DWELL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       mux;
        logic [1:0] sel;
        logic       sel_valid;
        logic [3:0] sample;
        logic       svld;
        logic       busy;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic st, input logic sp, input logic mx,
                                input logic [1:0] s, input logic v, input logic [3:0] smp,
                                input logic sv, input logic b);
        vec_t r;
        r.start = st; r.stop = sp; r.mux = mx;
        r.sel = s; r.sel_valid = v; r.sample = smp; r.svld = sv; r.busy = b;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until a sample_valid pulse is visible (bounded)
    task automatic wait_pulse(input string name, input int exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.sample_valid && n < 64);
        check(name, 32'(n), 32'(exp));
    endtask

    task automatic stop_to_idle(input string name);
        int n;
        n = 0;
        bus.stop = 1'b1;
        do begin
            step();
            n++;
        end while (bus.busy && n < 64);
        bus.stop = 1'b0;
        check(name, {31'd0, bus.busy}, 32'd0);
    endtask

    function automatic logic [8:0] outs();
        return {bus.sel, bus.sel_valid, bus.sample, bus.sample_valid, bus.busy};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.chan_mask = 4'h0;
        bus.dwell = 4'h0; bus.mux_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs()), 32'd0);
        rst = 1'b0;

        // Full sweep mask=1111 D=1, mux_in high only while sel=2, then a stop
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1);
        tbl[7]  = mk(1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[13] = mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 1'b1);
        tbl[17] = mk(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[19] = mk(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[21] = mk(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[22] = mk(1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[23] = mk(1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0100, 1'b0, 1'b1);
        tbl[24] = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0);
        tbl[25] = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);

        bus.chan_mask = 4'b1111;
        bus.dwell     = 4'd1;
        for (int i = 0; i < 26; i++) begin
            bus.start  = tbl[i].start;
            bus.stop   = tbl[i].stop;
            bus.mux_in = tbl[i].mux;
            step();
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({tbl[i].sel, tbl[i].sel_valid, tbl[i].sample, tbl[i].svld, tbl[i].busy}));
        end
        bus.stop = 1'b0;

        // Asynchronous reset mid-dwell
        bus.chan_mask = 4'b1111; bus.dwell = 4'd3; bus.mux_in = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step();
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1 check("rst_async_outs", 32'(outs()), 32'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_rst_idle%0d", i), {30'd0, bus.busy, bus.sel_valid}, 32'd0);
        end

        // Skip disabled channels: mask=1010, D=0
        bus.chan_mask = 4'b1010; bus.dwell = 4'd0; bus.mux_in = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("skip_sel_a", 32'(bus.sel), 32'd1);
        step();
        check("skip_sel_b", 32'(bus.sel), 32'd3);
        step();
        check("skip_pulse", {27'd0, bus.sel, bus.sample, bus.sample_valid}, {27'd0, 2'd1, 4'b1010, 1'b1});
        wait_pulse("skip_period", 2);
        check("skip_sample", 32'(bus.sample), 32'hA);
        stop_to_idle("skip_idle");

        // Stop pulsed during channel 0: sweep finishes channel 1 then halts
        bus.chan_mask = 4'b0011; bus.dwell = 4'd2; bus.mux_in = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        step();
        bus.stop  = 1'b0;
        check("stop_still_ch0", 32'(bus.sel), 32'd0);
        wait_pulse("stop_pulse_delay", 5);
        check("stop_end_state", {30'd0, bus.busy, bus.sel_valid}, 32'd0);
        step();
        check("stop_single_pulse", {30'd0, bus.sample_valid, bus.busy}, 32'd0);

        // Start with an empty mask is ignored
        bus.chan_mask = 4'b0000; bus.start = 1'b1;
        step(); step();
        check("start_mask0", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;

        // Mid-sweep mask change applies only from the next sweep
        bus.chan_mask = 4'b1111; bus.dwell = 4'd1; bus.mux_in = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_pulse("mask_first", 8);
        check("mask_sample_f", 32'(bus.sample), 32'hF);
        step(); step();
        bus.chan_mask = 4'b0001;
        wait_pulse("mask_old_period", 6);
        check("mask_sample_f2", 32'(bus.sample), 32'hF);
        wait_pulse("mask_new_period", 2);
        check("mask_sample_1", 32'(bus.sample), 32'h1);
        stop_to_idle("mask_idle");

        // Dwell relatch: 0 -> 5 mid-sweep with a single channel
        bus.chan_mask = 4'b0001; bus.dwell = 4'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.dwell = 4'd5;
        wait_pulse("dwell_old_window", 1);
        wait_pulse("dwell_new_window", 6);
        wait_pulse("dwell_steady", 6);
        stop_to_idle("dwell_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
